clk_rate_detect: RTL and testbench

//  Receive-side companion of the game-clock divider. Observes the divided game clock
//  (clk_game) in the system clock domain, measures its half-period and decodes it back

---
 rtl/clk_rate_detect.sv | 165 ++++++++++++++++
 tb/tb_clk_rate_detect.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_detect.sv
// Game-clock rate detector: measures clk_game half-period in the clk domain
// and decodes it back to the 1x/2x/4x/8x rate code, flagging loss of lock.
module clk_rate_detect #(
  parameter int unsigned BASE  = 12500,
  parameter int unsigned TOL   = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_game,
  output logic [1:0]       rate_code,
  output logic             rate_valid,
  output logic             rate_upd,
  output logic             rate_err,
  output logic [CNT_W-1:0] half_period
);

  localparam int unsigned W = CNT_W + 2;

  localparam logic [W-1:0] TOL_W = W'(TOL);
  localparam logic [W-1:0] TGT1  = W'(BASE + 1);
  localparam logic [W-1:0] TGT2  = W'(2 * BASE + 1);
  localparam logic [W-1:0] TGT4  = W'(4 * BASE + 1);
  localparam logic [W-1:0] TGT8  = W'(8 * BASE + 1);
  localparam logic [W-1:0] TMO   = W'(8 * BASE + TOL + 2);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic             cand_ok_q, cand_ok_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] hp_q, hp_d;

  logic             toggle;
  logic [W-1:0]     meas;
  logic             tmo;
  logic [1:0]       cls;
  logic             cls_ok;

  function automatic logic near(input logic [W-1:0] m,
                                input logic [W-1:0] t);
    logic [W-1:0] d;
    d = (m >= t) ? (m - t) : (t - m);
    return d <= TOL_W;
  endfunction

  assign toggle = sync2_q ^ prev_q;
  assign meas   = {2'b00, cnt_q} + W'(1);
  assign tmo    = meas >= TMO;

  // First match wins so overlapping windows still decode deterministically
  always_comb begin
    cls    = 2'd0;
    cls_ok = 1'b1;
    if (near(meas, TGT1))      cls = 2'd0;
    else if (near(meas, TGT2)) cls = 2'd1;
    else if (near(meas, TGT4)) cls = 2'd2;
    else if (near(meas, TGT8)) cls = 2'd3;
    else                       cls_ok = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = toggle ? '0 :
                (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    cand_d    = cand_q;
    cand_ok_d = cand_ok_q;
    code_d    = code_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    hp_d      = hp_q;
    case (state_q)
      IDLE: begin
        if (toggle) begin
          state_d   = MEASURE;
          cand_ok_d = 1'b0;
        end
      end
      MEASURE: begin
        if (toggle) begin
          hp_d = meas[CNT_W-1:0];
          if (cls_ok && cand_ok_q && cls == cand_q) begin
            state_d = LOCKED;
            code_d  = cls;
            valid_d = 1'b1;
            upd_d   = 1'b1;
          end else begin
            cand_d    = cls;
            cand_ok_d = cls_ok;
          end
        end else if (tmo) begin
          state_d   = IDLE;
          cand_ok_d = 1'b0;
          valid_d   = 1'b0;
        end
      end
      LOCKED: begin
        if (toggle) begin
          hp_d = meas[CNT_W-1:0];
          if (!(cls_ok && cls == code_q)) begin
            state_d   = MEASURE;
            err_d     = 1'b1;
            valid_d   = 1'b0;
            cand_d    = cls;
            cand_ok_d = cls_ok;
          end
        end else if (tmo) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          valid_d   = 1'b0;
          cand_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      cand_q    <= 2'd0;
      cand_ok_q <= 1'b0;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      hp_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= clk_game;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      cand_ok_q <= cand_ok_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      hp_q      <= hp_d;
    end
  end

  assign rate_code   = code_q;
  assign rate_valid  = valid_q;
  assign rate_upd    = upd_q;
  assign rate_err    = err_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_clk_rate_detect.sv
// Bench for clk_rate_detect: interval-level reference model feeding an
// event scoreboard, plus settled-state checks after each burst.
module tb_clk_rate_detect;

  localparam int BASE  = 4;
  localparam int TOL   = 1;
  localparam int CNT_W = 32;
  localparam int TMO   = 8 * BASE + TOL + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clk_game = 1'b0;
  logic [1:0]       rate_code;
  logic             rate_valid;
  logic             rate_upd;
  logic             rate_err;
  logic [CNT_W-1:0] half_period;

  clk_rate_detect #(
    .BASE (BASE),
    .TOL  (TOL),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_game   (clk_game),
    .rate_code  (rate_code),
    .rate_valid (rate_valid),
    .rate_upd   (rate_upd),
    .rate_err   (rate_err),
    .half_period(half_period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int       cyc;
    bit       upd;
    bit       err;
    bit       valid;
    int       code;
    int       hp;
  } ev_t;

  ev_t q[$];

  // Reference model: 0 idle, 1 measuring, 2 locked; times are detect edges
  int mst = 0;
  int mlast = 0;
  int mcand = 0;
  bit mcok = 0;
  bit mvalid = 0;
  int mcode = 0;
  int mhp = 0;
  int lastdrv = 0;

  function automatic int cls_of(int m);
    for (int i = 0; i < 4; i++) begin
      int nom;
      nom = BASE * (1 << i) + 1;
      if (m >= nom - TOL && m <= nom + TOL) return i;
    end
    return -1;
  endfunction

  function automatic void push(int c, bit u, bit e);
    ev_t x;
    x.cyc = c;
    x.upd = u;
    x.err = e;
    x.valid = mvalid;
    x.code = mcode;
    x.hp = mhp;
    q.push_back(x);
  endfunction

  function automatic void m_adv(int t);
    bit was;
    if (mst != 0 && t - mlast > TMO) begin
      was = (mst == 2);
      mst = 0;
      mvalid = 0;
      mcok = 0;
      if (was) push(mlast + TMO, 0, 1);
    end
  endfunction

  function automatic void m_tog(int t);
    int m;
    int c;
    m = t - mlast;
    c = cls_of(m);
    case (mst)
      0: begin
        mst = 1;
        mcok = 0;
      end
      1: begin
        mhp = m;
        if (c >= 0 && mcok && c == mcand) begin
          mst = 2;
          mcode = c;
          mvalid = 1;
          push(t, 1, 0);
        end else begin
          mcand = c;
          mcok = (c >= 0);
        end
      end
      default: begin
        mhp = m;
        if (c != mcode) begin
          mst = 1;
          mvalid = 0;
          mcand = c;
          mcok = (c >= 0);
          push(t, 0, 1);
        end
      end
    endcase
    mlast = t;
  endfunction

  function automatic void m_reset();
    mst = 0;
    mvalid = 0;
    mcode = 0;
    mhp = 0;
    mcok = 0;
    mcand = 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the next predicted event
  always @(negedge clk) begin
    if (rst_n && (rate_upd || rate_err)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: upd=%0b err=%0b at cyc %0d, want none",
                 rate_upd, rate_err, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.upd != rate_upd || e.err != rate_err ||
            e.valid != rate_valid || e.code != int'(rate_code) ||
            e.hp != int'(half_period)) begin
          fails++;
          $display("FAIL event: got cyc=%0d upd=%0b err=%0b valid=%0b code=%0d hp=%0d, want cyc=%0d upd=%0b err=%0b valid=%0b code=%0d hp=%0d",
                   cyc, rate_upd, rate_err, rate_valid, rate_code, half_period,
                   e.cyc, e.upd, e.err, e.valid, e.code, e.hp);
        end
      end
    end
  end

  task automatic tog(int iv);
    int tgt;
    tgt = lastdrv + iv;
    if (tgt <= cyc) tgt = cyc + 1;
    m_adv(tgt + 3);
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
    clk_game = ~clk_game;
    m_tog(tgt + 3);
    lastdrv = tgt;
  endtask

  task automatic settle();
    @(negedge clk);
    while (cyc < lastdrv + 4) @(negedge clk);
    chk("valid", int'(rate_valid), int'(mvalid));
    chk("code", int'(rate_code), mcode);
    chk("half_period", int'(half_period), mhp);
  endtask

  task automatic hold(int n);
    m_adv(cyc + n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_code"}, int'(rate_code), 0);
    chk({nm, "_valid"}, int'(rate_valid), 0);
    chk({nm, "_upd"}, int'(rate_upd), 0);
    chk({nm, "_err"}, int'(rate_err), 0);
    chk({nm, "_hp"}, int'(half_period), 0);
  endtask

  task automatic do_reset();
    if (clk_game) tog(BASE + 1);
    settle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lastdrv = cyc;
  endtask

  initial begin
    int k;
    int n;
    int sel;
    int iv;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    lastdrv = cyc;

    // lock at 9-clk intervals
    repeat (3) tog(9);
    settle();
    // move to k=4, then to k=8
    repeat (3) tog(17);
    settle();
    repeat (2) tog(33);
    settle();
    // tolerance window around 17
    repeat (2) tog(17);
    tog(16);
    tog(18);
    tog(16);
    tog(18);
    settle();
    tog(15);
    settle();
    // lock at 5, stall, resume
    repeat (2) tog(5);
    settle();
    hold(60);
    chk("tmo_valid", int'(rate_valid), 0);
    repeat (3) tog(5);
    settle();
    // async reset while locked, then relock
    do_reset();
    repeat (3) tog(9);
    settle();
    // unclassifiable intervals
    hold(60);
    repeat (3) tog(7);
    settle();

    for (int r = 0; r < 40; r++) begin
      k = 1 << $urandom_range(0, 3);
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)
          iv = BASE * k + 1 + $urandom_range(0, 2) - 1;
        else if (sel == 7)
          iv = $urandom_range(3, 40);
        else
          iv = BASE * (1 << $urandom_range(0, 3)) + 1;
        tog(iv);
      end
      settle();
      if ($urandom_range(0, 3) == 0) hold(60);
      if (r % 10 == 9) do_reset();
    end

    hold(60);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
